// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with prescaled tick, wrap pulse and multiplexed digit scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (val=4'hF) on digits 3..1.
module bcd_scan_counter #(
   parameter int PRESCALE = 1000,
   parameter int SCAN_DIV = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        up,
   input  logic        clr,
   output logic [15:0] count,
   output logic [3:0]  val,
   output logic [3:0]  dig_sel,
   output logic        wrap
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

   logic [PW-1:0] presc;
   logic [SW-1:0] scan;
   logic [1:0]    idx;
   logic          tick;
   logic          roll;
   logic          carry;
   logic [3:0]    d;
   logic [15:0]   count_nxt;
   logic [3:0]    digit;
   logic          blank;

   assign tick = en && (presc == PRESC_LAST);
   assign roll = up ? (count == 16'h9999) : (count == 16'h0000);

   // Ripple carry/borrow across digits; a digit only changes while the carry is live.
   always_comb begin
      count_nxt = count;
      carry     = 1'b1;
      d         = 4'd0;
      for (int i = 0; i < 4; i++) begin
         d = count[i*4 +: 4];
         if (carry) begin
            if (up) begin
               if (d == 4'd9) begin
                  d = 4'd0;
               end else begin
                  d     = d + 4'd1;
                  carry = 1'b0;
               end
            end else begin
               if (d == 4'd0) begin
                  d = 4'd9;
               end else begin
                  d     = d - 4'd1;
                  carry = 1'b0;
               end
            end
            count_nxt[i*4 +: 4] = d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         presc <= '0;
         count <= 16'h0000;
         wrap  <= 1'b0;
      end else begin
         if (en) begin
            presc <= tick ? '0 : presc + 1'b1;
         end
         if (tick) begin
            count <= count_nxt;
         end
         wrap <= tick && roll;
      end
   end

   assign digit = count[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin
      blank = 1'b0;
      case (idx)
         2'd1:    blank = (count[15:4]  == 12'h000);
         2'd2:    blank = (count[15:8]  == 8'h00);
         2'd3:    blank = (count[15:12] == 4'h0);
         default: blank = 1'b0;
      endcase
   end
`else
   assign blank = 1'b0;
`endif

   // Scan runs free of en/clr; val and dig_sel are captured together from the same idx.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan    <= '0;
         idx     <= 2'd0;
         val     <= 4'h0;
         dig_sel <= 4'b0001;
      end else begin
         if (scan == SCAN_LAST) begin
            scan <= '0;
            idx  <= idx + 2'd1;
         end else begin
            scan <= scan + 1'b1;
         end
         val     <= blank ? 4'hF : digit;
         dig_sel <= 4'b0001 << idx;
      end
   end
endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench: decimal reference model for the counter and scan, plus a PRESCALE=5 instance.
module tb_bcd_scan_counter;
   localparam int P  = 1;
   localparam int SD = 4;

   logic        clk = 1'b0;
   logic        rst, en, up, clr;
   logic [15:0] count;
   logic [3:0]  val, dig_sel;
   logic        wrap;

   logic        rst5, en5;
   logic [15:0] count5;
   logic [3:0]  val5, dig_sel5;
   logic        wrap5;

   int checks   = 0;
   int failures = 0;
   int wrap_seen;

   int m_cnt, m_presc, m_scan, m_idx;

   typedef struct {
      logic [15:0] count;
      logic        wrap;
      logic [3:0]  val;
      logic [3:0]  dig;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   bcd_scan_counter #(.PRESCALE(P), .SCAN_DIV(SD)) u_dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr),
      .count(count), .val(val), .dig_sel(dig_sel), .wrap(wrap)
   );

   bcd_scan_counter #(.PRESCALE(5), .SCAN_DIV(SD)) u_p5 (
      .clk(clk), .rst(rst5), .en(en5), .up(1'b1), .clr(1'b0),
      .count(count5), .val(val5), .dig_sel(dig_sel5), .wrap(wrap5)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
      checks++;
      if (got !== exp_v) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp_v, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic step(input logic i_en, input logic i_up, input logic i_clr, input logic i_rst);
      exp_t e;
      int   pw;
      int   dv;
      bit   tk;
      @(negedge clk);
      en  = i_en;
      up  = i_up;
      clr = i_clr;
      rst = i_rst;
      if (i_rst) begin
         e = '{16'h0000, 1'b0, 4'h0, 4'b0001};
         m_cnt = 0; m_presc = 0; m_scan = 0; m_idx = 0;
      end else begin
         pw = 1;
         for (int k = 0; k < m_idx; k++) pw = pw * 10;
         dv = (m_cnt / pw) % 10;
`ifdef LEADING_ZERO_BLANK_EN
         if (m_idx > 0 && m_cnt < pw) dv = 15;
`endif
         e.val  = 4'(dv);
         e.dig  = 4'(1 << m_idx);
         e.wrap = 1'b0;
         tk = i_en && (m_presc == P - 1);
         if (i_clr) begin
            m_cnt = 0;
            m_presc = 0;
         end else begin
            if (i_en) m_presc = tk ? 0 : m_presc + 1;
            if (tk) begin
               if (i_up) begin
                  e.wrap = (m_cnt == 9999);
                  m_cnt  = (m_cnt + 1) % 10000;
               end else begin
                  e.wrap = (m_cnt == 0);
                  m_cnt  = (m_cnt + 9999) % 10000;
               end
            end
         end
         if (m_scan == SD - 1) begin
            m_scan = 0;
            m_idx  = (m_idx + 1) % 4;
         end else begin
            m_scan++;
         end
         e.count = to_bcd(m_cnt);
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("count", 32'(count), 32'(e.count));
      chk("wrap", 32'(wrap), 32'(e.wrap));
      chk("val", 32'(val), 32'(e.val));
      chk("dig_sel", 32'(dig_sel), 32'(e.dig));
      chk("onehot", 32'($onehot(dig_sel)), 32'd1);
      if (wrap) wrap_seen++;
   endtask

   task automatic step5(input logic i_en, input logic i_rst);
      @(negedge clk);
      en5  = i_en;
      rst5 = i_rst;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0;
      rst5 = 1'b1; en5 = 1'b0;

      // Reset state, then a full up cycle with one roll-over.
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      wrap_seen = 0;
      for (int i = 0; i < 10000; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("wrap_once", 32'(wrap_seen), 32'd1);
      chk("full_cycle", 32'(count), 32'h0000);

      // Clear, down through 0000 -> 9999 -> 9998.
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("down_wrap_cnt", 32'(count), 32'h9999);
      chk("down_wrap_pulse", 32'(wrap), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("down_9998", 32'(count), 32'h9998);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // 0199 -> 0200 -> 0199, then clr beats a simultaneous tick.
      step(1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 199; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("carry_0200", 32'(count), 32'h0200);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("borrow_0199", 32'(count), 32'h0199);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("clr_prio", 32'(count), 32'h0000);
      chk("clr_no_wrap", 32'(wrap), 32'd0);

      // 1234 held while the scan is observed.
      for (int i = 0; i < 1234; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

      // 0007 and 0000 scanned (leading-zero blanking when enabled).
      step(1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 1'b0);

      // Mid-run reset, alternating direction and enable afterwards.
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) step(1'(i % 3 != 0), 1'(i % 2), 1'b0, 1'b0);

      // PRESCALE=5: phase held across en low, resumes after 2 enabled cycles.
      step5(1'b0, 1'b1);
      chk("p5_reset", 32'(count5), 32'h0000);
      chk("p5_reset_dig", 32'(dig_sel5), 32'b0001);
      for (int i = 0; i < 3; i++) step5(1'b1, 1'b0);
      chk("p5_after3", 32'(count5), 32'h0000);
      for (int i = 0; i < 10; i++) step5(1'b0, 1'b0);
      chk("p5_hold", 32'(count5), 32'h0000);
      step5(1'b1, 1'b0);
      chk("p5_resume1", 32'(count5), 32'h0000);
      step5(1'b1, 1'b0);
      chk("p5_resume2", 32'(count5), 32'h0001);
      chk("p5_no_wrap", 32'(wrap5), 32'd0);
      for (int i = 0; i < 3; i++) step5(1'b1, 1'b0);
      step5(1'b0, 1'b1);
      chk("p5_midreset", 32'(count5), 32'h0000);
      for (int i = 0; i < 4; i++) step5(1'b1, 1'b0);
      chk("p5_restart4", 32'(count5), 32'h0000);
      step5(1'b1, 1'b0);
      chk("p5_restart5", 32'(count5), 32'h0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 Parameter PRESCALE, default 1000, clk cycles per count tick; legal range >= 1.
REQ-002 Parameter SCAN_DIV, default 100, clk cycles each digit is held on the display; legal range >= 1.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port en  input  1  count enable; high lets the prescaler run and ticks apply.
REQ-006 Port up  input  1  direction; 1 counts up, 0 counts down; sampled on each tick.
REQ-007 Port clr  input  1  synchronous clear of the count and the prescaler.
REQ-008 Port count  output  16  packed BCD count, digit 3 in [15:12] down to digit 0 in [3:0].
REQ-009 Port val  output  4  BCD code of the currently scanned digit, feeding the 7-segment decoder.
REQ-010 Port dig_sel  output  4  one-hot active-high digit enable; bit n selects digit n.
REQ-011 Port wrap  output  1  one-cycle pulse on a 9999->0000 or 0000->9999 roll-over.

Function
REQ-012 The prescaler SHALL count 0..PRESCALE-1 while en=1, hold its value while en=0, and assert an internal tick in the cycle it equals PRESCALE-1 with en=1; it wraps to 0 on the next edge. PRESCALE=1 gives a tick every enabled cycle.
REQ-013 On tick with up=1, count SHALL increment as 4-digit BCD with ripple carry (e.g. 0199->0200); every digit SHALL stay within 0..9.
REQ-014 On tick with up=0, count SHALL decrement as 4-digit BCD with ripple borrow (e.g. 0200->0199).
REQ-015 Wrap-around: up at 9999 gives 0000, down at 0000 gives 9999; wrap SHALL be 1 in the cycle after that edge only.
REQ-016 clr=1 SHALL set count=0000 and the prescaler to 0 on the next edge, with priority over any tick; no wrap pulse is produced. The scan logic SHALL be unaffected.
REQ-017 The scan counter SHALL run every cycle regardless of en or clr, counting 0..SCAN_DIV-1; at SCAN_DIV-1 the digit index SHALL advance 0->1->2->3->0.
REQ-018 val and dig_sel SHALL be registered together from the current digit index and count; they lag the internal state by exactly 1 cycle and SHALL never disagree in the same cycle.
REQ-019 dig_sel SHALL always be exactly one-hot (never 0, never more than one bit set).
REQ-020 count SHALL be a direct register output: it changes on the edge that consumes the tick, with 0 cycles of added latency.
REQ-021 A change of up between ticks SHALL affect only the next tick; the prescaler phase SHALL be preserved across en toggles.

Reset
REQ-022 rst=1 SHALL take priority over all other inputs and, on the next edge, set count=0000, prescaler=0, scan counter=0, digit index=0, val=0, dig_sel=4'b0001, wrap=0.
REQ-023 Reset asserted mid-scan or mid-prescale SHALL discard the partial progress; counting resumes from prescaler 0 on the first cycle after rst deasserts.

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN, when defined: while scanned digit n (n>=1) is 0 and all higher digits are 0, val SHALL be 4'hF, which the decoder renders as all segments off; dig_sel is unchanged and digit 0 is never blanked.
REQ-025 LEADING_ZERO_BLANK_EN undefined: val SHALL always carry the digit's BCD value; no blanking logic is present.

Verification (PRESCALE=1, SCAN_DIV=4 unless stated)
REQ-026 Set en=1, up=1, run 10000 ticks from 0000 -> count returns to 0000; wrap pulses exactly once, one cycle after the 9999->0000 edge.
REQ-027 Load 0000 via clr, set up=0 and en=1 for 1 tick -> count=9999 and wrap=1 for one cycle; a further tick gives count=9998.
REQ-028 Set count=0199 and apply 1 up tick -> count=0200; apply clr and a tick in the same cycle -> count=0000, wrap=0.
REQ-029 With count=1234, watch 16 cycles -> dig_sel steps 0001,0010,0100,1000 every 4 cycles and val shows 4,3,2,1 in step with dig_sel; dig_sel is always one-hot.
REQ-030 With PRESCALE=5, en=1 for 3 cycles, en=0 for 10 cycles, then en=1 -> the tick arrives after 2 more enabled cycles and count increments once.
REQ-031 With LEADING_ZERO_BLANK_EN defined and count=0007 -> val=F on digits 3,2,1 and val=7 on digit 0; with count=0000 -> digit 0 shows val=0.
